hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Companion to the EX-stage forwarding unit. It handles the hazards that forwarding cannot resolve: load-use, multi-cycle mult/div HI/LO dependencies, and taken-branch flush.
- Sits at the IF/ID boundary.
- Drives PC and IF/ID write enables, the ID/EX bubble insert, and the IF/ID flush.
- Owns the mult/div busy counter and a stall-cycle performance counter.

Parameters:
- MD_LATENCY, 32, cycles a mult/div occupies HI/LO after issue in EX (legal range 2..63)
- CNT_W, 16, width of the stall-cycle performance counter

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous reset, active low
- rs_if_id  in  5  rs field of the instruction in decode
- rt_if_id  in  5  rt field of the instruction in decode
- uses_rs_id  in  1  decode instruction reads rs
- uses_rt_id  in  1  decode instruction reads rt
- uses_hilo_id  in  1  decode instruction is mfhi/mflo
- md_id  in  1  decode instruction is mult/multu/div/divu
- dstn_rr_ex  in  5  destination register of the instruction in EX
- MemRead_rr_ex  in  1  instruction in EX is a load
- md_start  in  1  mult/div issuing in EX this cycle
- branch_taken_ex  in  1  branch/jump resolved taken in EX
- pc_write  out  1  PC register enable
- if_id_write  out  1  IF/ID register enable
- bubble_rr  out  1  zero the ID/EX control fields (insert nop)
- flush_if_id  out  1  replace the IF/ID contents with a nop
- md_busy  out  1  HI/LO result not yet valid
- stall_cycles  out  CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: single clock domain on clk. rst_n is sampled on the rising edge only.
- Reset, while rst_n=0:
  - md_cnt=0, md_busy=0, stall_cycles=0.
  - Combinational outputs are forced to pc_write=0, if_id_write=0, bubble_rr=1, flush_if_id=0.
- Hazard terms, all combinational and zero-latency (decided in the same cycle they are visible):
  - load_use = MemRead_rr_ex && dstn_rr_ex!=0 && ((uses_rs_id && dstn_rr_ex==rs_if_id) || (uses_rt_id && dstn_rr_ex==rt_if_id)).
  - md_haz = md_busy && (uses_hilo_id || md_id).
  - stall = load_use || md_haz.
- Priority, highest first:
  1. Reset.
  2. Flush, when branch_taken_ex=1: flush_if_id=1, bubble_rr=1, pc_write=1 (PC takes the target), if_id_write=1. Any stall in the same cycle is discarded, because the decode instruction is wrong-path.
  3. Stall: pc_write=0, if_id_write=0, bubble_rr=1, flush_if_id=0.
  4. Run: pc_write=1, if_id_write=1, bubble_rr=0, flush_if_id=0.
- Mult/div counter (md_cnt, 6 bits, state IDLE when 0, BUSY otherwise):
  - IDLE and md_start: md_cnt <= MD_LATENCY-1.
  - BUSY: md_cnt decrements by 1 per cycle regardless of stall or flush, since the operation in EX has already committed.
  - md_busy = (md_cnt != 0), registered. md_busy is first high the cycle after md_start and stays high for MD_LATENCY-1 cycles.
  - md_start while BUSY is ignored, with no reload. Upstream cannot produce this because md_haz stalls the md instruction.
  - md_start together with branch_taken_ex: the counter still loads. The md instruction is in EX, ahead of the branch shadow.
- Load-use duration: the stall lasts exactly 1 cycle. Next cycle the load is in MEM and forwarding resolves it. No state is needed.
- stall_cycles:
  - +1 on each cycle where the stall term wins (priority 3).
  - Flush cycles are not counted.
  - Saturates at all-ones with no wrap.
- Register r0: a load to r0 never stalls.

Decomposition:
- Shared pipeline package holds:
  - the forwarding/hazard control constants, including the nop encoding used by bubble and flush;
  - the register-index width (5);
  - MD_LATENCY default.
- One natural sub-module, md_busy_counter: load, decrement, busy flag.
- The priority mux and the hazard compare stay in the top module.

Test Plan:
- Load-use on rt: lw r5 in EX (MemRead_rr_ex=1, dstn_rr_ex=5); decode add with rt=5, uses_rt_id=1 -> 1 cycle of pc_write=0, if_id_write=0, bubble_rr=1; next cycle run; stall_cycles=1.
- Load to r0 or unused operand: dstn_rr_ex=0, or rs match with uses_rs_id=0 -> no stall, stall_cycles unchanged.
- Mult/div stall, MD_LATENCY=4: md_start at cycle 0; mfhi enters decode at cycle 1 -> md_busy high for cycles 1-3; stall for cycles 1-3; run at cycle 4; stall_cycles=3.
- Flush beats stall: load_use true and branch_taken_ex=1 in the same cycle -> flush_if_id=1, bubble_rr=1, pc_write=1, stall_cycles unchanged.
- Mid-operation reset: md_start, then rst_n=0 for 1 cycle at md_cnt=2 -> md_busy=0 and stall_cycles=0 the next cycle; outputs forced to their reset values while rst_n=0.
- Saturation: CNT_W=4, 20 consecutive md_haz stall cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit_pkg
// Shared pipeline constants for the IF/ID hazard logic and its companion
// EX-stage forwarding unit.
//   - REG_IDX_W          : register-index width
//   - MD_CNT_W           : width of the mult/div occupancy counter
//   - MD_LATENCY_DEFAULT : default HI/LO occupancy after a mult/div issues
//   - NOP_INSTR          : encoding injected by a bubble or a flush
//   - fwd_sel_e          : forwarding mux selects used by the EX stage
//   - hz_action_e        : which front-end action wins this cycle
//   - pipe_ctrl_t        : bundle of front-end enables driven per action
// ---------------------------------------------------------------------------
package hazard_stall_unit_pkg;

    localparam int REG_IDX_W          = 5;
    localparam int MD_CNT_W           = 6;
    localparam int MD_LATENCY_DEFAULT = 32;

    // sll r0, r0, 0 : the canonical MIPS nop
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        HZ_RUN,
        HZ_STALL,
        HZ_FLUSH,
        HZ_RESET
    } hz_action_e;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic bubble_rr;
        logic flush_if_id;
    } pipe_ctrl_t;

    // Front-end enables for each action.
    function automatic pipe_ctrl_t action_ctrl(input hz_action_e act);
        pipe_ctrl_t c;
        case (act)
            HZ_RESET: c = '{pc_write: 1'b0, if_id_write: 1'b0, bubble_rr: 1'b1, flush_if_id: 1'b0};
            HZ_FLUSH: c = '{pc_write: 1'b1, if_id_write: 1'b1, bubble_rr: 1'b1, flush_if_id: 1'b1};
            HZ_STALL: c = '{pc_write: 1'b0, if_id_write: 1'b0, bubble_rr: 1'b1, flush_if_id: 1'b0};
            default:  c = '{pc_write: 1'b1, if_id_write: 1'b1, bubble_rr: 1'b0, flush_if_id: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_counter.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit_md_busy_counter
// Tracks how long a mult/div issued in EX keeps HI/LO invalid.
//   clk      in  pipeline clock
//   rst_n    in  synchronous reset, active low
//   md_start in  mult/div issuing in EX this cycle
//   md_busy  out HI/LO result not yet valid (high MD_LATENCY-1 cycles,
//                starting the cycle after md_start)
// ---------------------------------------------------------------------------
module hazard_stall_unit_md_busy_counter
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    output logic md_busy
);

    localparam logic [MD_CNT_W-1:0] LOAD_VAL = MD_CNT_W'(MD_LATENCY - 1);

    logic [MD_CNT_W-1:0] md_cnt;
    md_state_e           md_state;

    assign md_state = (md_cnt == '0) ? MD_IDLE : MD_BUSY;

    // Once loaded the count always runs down: the operation has already
    // committed in EX, so stalls and flushes do not hold it. A second
    // md_start while busy is ignored (upstream stalls it in decode).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else begin
            case (md_state)
                MD_IDLE: if (md_start) md_cnt <= LOAD_VAL;
                MD_BUSY: md_cnt <= md_cnt - MD_CNT_W'(1);
                default: md_cnt <= '0;
            endcase
        end
    end

    assign md_busy = (md_state == MD_BUSY);

endmodule

// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
// Resolves the hazards forwarding cannot: load-use, HI/LO use while a
// mult/div is still running, and taken-branch flush. Sits at IF/ID.
//   clk, rst_n                   clock, synchronous active-low reset
//   rs_if_id, rt_if_id           decode source register fields
//   uses_rs_id, uses_rt_id       decode reads rs / rt
//   uses_hilo_id, md_id          decode is mfhi/mflo / mult-div
//   dstn_rr_ex, MemRead_rr_ex    EX destination and load flag
//   md_start                     mult/div issuing in EX
//   branch_taken_ex              branch/jump resolved taken in EX
//   pc_write, if_id_write        front-end register enables
//   bubble_rr                    zero ID/EX control (insert nop)
//   flush_if_id                  replace IF/ID with a nop
//   md_busy                      HI/LO not yet valid
//   stall_cycles                 saturating count of stall cycles
// ---------------------------------------------------------------------------
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] rs_if_id,
    input  logic [REG_IDX_W-1:0] rt_if_id,
    input  logic                 uses_rs_id,
    input  logic                 uses_rt_id,
    input  logic                 uses_hilo_id,
    input  logic                 md_id,
    input  logic [REG_IDX_W-1:0] dstn_rr_ex,
    input  logic                 MemRead_rr_ex,
    input  logic                 md_start,
    input  logic                 branch_taken_ex,
    output logic                 pc_write,
    output logic                 if_id_write,
    output logic                 bubble_rr,
    output logic                 flush_if_id,
    output logic                 md_busy,
    output logic [CNT_W-1:0]     stall_cycles
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic       load_use;
    logic       md_haz;
    logic       stall;
    hz_action_e action;
    pipe_ctrl_t ctrl;

    hazard_stall_unit_md_busy_counter #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_busy_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (md_start),
        .md_busy  (md_busy)
    );

    // r0 is hardwired zero, so a load targeting it never creates a hazard.
    assign load_use = MemRead_rr_ex && (dstn_rr_ex != '0) &&
                      ((uses_rs_id && (dstn_rr_ex == rs_if_id)) ||
                       (uses_rt_id && (dstn_rr_ex == rt_if_id)));

    // A new mult/div would also clobber HI/LO, so it waits like mfhi/mflo.
    assign md_haz = md_busy && (uses_hilo_id || md_id);
    assign stall  = load_use || md_haz;

    // A taken branch means decode holds a wrong-path instruction, so its
    // stall request is meaningless and the flush wins.
    always_comb begin
        action = HZ_RUN;
        if (!rst_n)
            action = HZ_RESET;
        else if (branch_taken_ex)
            action = HZ_FLUSH;
        else if (stall)
            action = HZ_STALL;
    end

    assign ctrl        = action_ctrl(action);
    assign pc_write    = ctrl.pc_write;
    assign if_id_write = ctrl.if_id_write;
    assign bubble_rr   = ctrl.bubble_rr;
    assign flush_if_id = ctrl.flush_if_id;

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (action == HZ_STALL)
            stall_cycles <= sat_inc(stall_cycles);
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_if_id, rt_if_id, dstn_rr_ex;
    logic       uses_rs_id, uses_rt_id, uses_hilo_id, md_id;
    logic       MemRead_rr_ex, md_start, branch_taken_ex;

    logic        pc_write, if_id_write, bubble_rr, flush_if_id, md_busy;
    logic [15:0] stall_cycles;

    logic        s_pc_write, s_if_id_write, s_bubble_rr, s_flush_if_id, s_md_busy;
    logic [3:0]  s_stall_cycles;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_if_id(rs_if_id), .rt_if_id(rt_if_id),
        .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
        .uses_hilo_id(uses_hilo_id), .md_id(md_id),
        .dstn_rr_ex(dstn_rr_ex), .MemRead_rr_ex(MemRead_rr_ex),
        .md_start(md_start), .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .bubble_rr(bubble_rr), .flush_if_id(flush_if_id),
        .md_busy(md_busy), .stall_cycles(stall_cycles)
    );

    // Long mult/div and a narrow counter, used for the saturation sequence.
    hazard_stall_unit #(.MD_LATENCY(32), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .rs_if_id(rs_if_id), .rt_if_id(rt_if_id),
        .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
        .uses_hilo_id(uses_hilo_id), .md_id(md_id),
        .dstn_rr_ex(dstn_rr_ex), .MemRead_rr_ex(MemRead_rr_ex),
        .md_start(md_start), .branch_taken_ex(branch_taken_ex),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write),
        .bubble_rr(s_bubble_rr), .flush_if_id(s_flush_if_id),
        .md_busy(s_md_busy), .stall_cycles(s_stall_cycles)
    );

    // ctrl packing: {pc_write, if_id_write, bubble_rr, flush_if_id}
    localparam logic [3:0] C_RUN   = 4'b1100;
    localparam logic [3:0] C_STALL = 4'b0010;
    localparam logic [3:0] C_FLUSH = 4'b1111;
    localparam logic [3:0] C_RESET = 4'b0010;

    typedef struct {
        logic [4:0] rs, rt, dst;
        logic       urs, urt, uhilo, mdid, mr, br;
        logic [3:0] exp_ctrl;
        logic       exp_inc;
    } vec_t;

    vec_t vecs[12];
    int checks   = 0;
    int failures = 0;
    int exp_sc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ctrl_now();
        return {pc_write, if_id_write, bubble_rr, flush_if_id};
    endfunction

    task automatic clear_in();
        rs_if_id = 0; rt_if_id = 0; dstn_rr_ex = 0;
        uses_rs_id = 0; uses_rt_id = 0; uses_hilo_id = 0; md_id = 0;
        MemRead_rr_ex = 0; md_start = 0; branch_taken_ex = 0;
    endtask

    task automatic drive(input vec_t v);
        rs_if_id = v.rs; rt_if_id = v.rt; dstn_rr_ex = v.dst;
        uses_rs_id = v.urs; uses_rt_id = v.urt;
        uses_hilo_id = v.uhilo; md_id = v.mdid;
        MemRead_rr_ex = v.mr; branch_taken_ex = v.br; md_start = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                rs  rt  dst urs urt hl md mr br  ctrl     inc
        vecs[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, C_RUN,   0};
        vecs[1]  = '{5'd1, 5'd5, 5'd5, 1, 1, 0, 0, 1, 0, C_STALL, 1};
        vecs[2]  = '{5'd5, 5'd2, 5'd5, 1, 1, 0, 0, 1, 0, C_STALL, 1};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 1, 0, C_RUN,   0};
        vecs[4]  = '{5'd5, 5'd2, 5'd5, 0, 1, 0, 0, 1, 0, C_RUN,   0};
        vecs[5]  = '{5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0, C_RUN,   0};
        vecs[6]  = '{5'd1, 5'd5, 5'd5, 1, 1, 0, 0, 1, 1, C_FLUSH, 0};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, C_FLUSH, 0};
        vecs[8]  = '{5'd3, 5'd4, 5'd7, 1, 1, 0, 0, 1, 0, C_RUN,   0};
        vecs[9]  = '{5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, C_RUN,   0};
        vecs[10] = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, C_RUN,   0};
        vecs[11] = '{5'd9, 5'd31, 5'd31, 0, 1, 0, 0, 1, 0, C_STALL, 1};

        // Reset: outputs forced while rst_n=0, state cleared.
        clear_in();
        rst_n = 0;
        uses_hilo_id = 1;
        step();
        step();
        @(negedge clk); #1;
        chk("reset_ctrl", ctrl_now(), C_RESET);
        chk("reset_md_busy", md_busy, 0);
        chk("reset_stall_cycles", stall_cycles, 0);
        @(negedge clk);
        rst_n = 1;
        clear_in();

        // Table-driven single-cycle vectors with md_busy low.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("vec%0d_ctrl", i), ctrl_now(), vecs[i].exp_ctrl);
            step();
            if (vecs[i].exp_inc) exp_sc++;
            chk($sformatf("vec%0d_stall_cycles", i), stall_cycles, exp_sc);
        end

        // Load-use on rt lasts one cycle, then the pipeline runs.
        @(negedge clk);
        clear_in();
        MemRead_rr_ex = 1; dstn_rr_ex = 5; rt_if_id = 5; uses_rt_id = 1; rs_if_id = 2; uses_rs_id = 1;
        #1;
        chk("lu_stall_ctrl", ctrl_now(), C_STALL);
        step();
        exp_sc++;
        @(negedge clk);
        MemRead_rr_ex = 0; dstn_rr_ex = 0;
        #1;
        chk("lu_next_run_ctrl", ctrl_now(), C_RUN);
        chk("lu_stall_cycles", stall_cycles, exp_sc);

        // Mult/div: mfhi waits while HI/LO is busy (MD_LATENCY=4 -> 3 cycles).
        @(negedge clk);
        clear_in();
        md_start = 1;
        #1;
        chk("md_c0_busy", md_busy, 0);
        chk("md_c0_ctrl", ctrl_now(), C_RUN);
        step();
        @(negedge clk);
        md_start = 0;
        uses_hilo_id = 1;
        for (int c = 1; c <= 3; c++) begin
            #1;
            chk($sformatf("md_c%0d_busy", c), md_busy, 1);
            chk($sformatf("md_c%0d_ctrl", c), ctrl_now(), C_STALL);
            step();
            exp_sc++;
            @(negedge clk);
        end
        #1;
        chk("md_c4_busy", md_busy, 0);
        chk("md_c4_ctrl", ctrl_now(), C_RUN);
        chk("md_stall_cycles", stall_cycles, exp_sc);

        // Flush beats a load-use stall; md_start in the same cycle still loads.
        @(negedge clk);
        clear_in();
        MemRead_rr_ex = 1; dstn_rr_ex = 6; rs_if_id = 6; uses_rs_id = 1;
        branch_taken_ex = 1; md_start = 1;
        #1;
        chk("flush_ctrl", ctrl_now(), C_FLUSH);
        step();
        chk("flush_stall_cycles", stall_cycles, exp_sc);
        chk("flush_md_loaded", md_busy, 1);
        @(negedge clk);
        clear_in();
        step(); step(); step();
        chk("flush_md_done", md_busy, 0);

        // Mid-operation reset at md_cnt=2.
        @(negedge clk);
        clear_in();
        md_start = 1;
        step();
        @(negedge clk);
        md_start = 0;
        step();
        @(negedge clk);
        chk("mid_busy_before", md_busy, 1);
        rst_n = 0;
        uses_hilo_id = 1;
        #1;
        chk("mid_reset_ctrl", ctrl_now(), C_RESET);
        step();
        chk("mid_reset_md_busy", md_busy, 0);
        chk("mid_reset_stall_cycles", stall_cycles, 0);
        @(negedge clk);
        rst_n = 1;
        clear_in();
        exp_sc = 0;

        // Saturation: 20 consecutive md_haz stalls into a 4-bit counter.
        @(negedge clk);
        md_start = 1;
        step();
        @(negedge clk);
        md_start = 0;
        uses_hilo_id = 1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if (c == 14) chk("sat_at14", s_stall_cycles, 14);
            if (c == 15) chk("sat_at15", s_stall_cycles, 15);
        end
        chk("sat_hold15", s_stall_cycles, 15);
        chk("sat_still_busy", s_md_busy, 1);
        chk("sat_main_count", stall_cycles, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
